pokey_pcm_decimator: RTL

//  Downstream of the POKEY volume mixer. Converts the 1-bit PWM audio stream (aud) into PCM samples.

---
 rtl/pokey_pcm_decimator.sv | 83 ++++++++
 1 files changed

// File: rtl/pokey_pcm_decimator.sv
// PWM-to-PCM decimator: counts high cycles of the mixer PWM per window, scales
// each window count to OUT_W bits and queues it in a small valid/ready FIFO.
module pokey_pcm_decimator #(
  parameter int LOG2_DECIM = 6,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter bit SIGNED_OUT = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          clr_i,
  input  logic                          pwmIn_i,
  output logic [OUT_W-1:0]              sampleData_o,
  output logic                          sampleValid_o,
  input  logic                          sampleReady_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount_o,
  output logic                          overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PAD_W = OUT_W - LOG2_DECIM;

  logic [LOG2_DECIM-1:0]              win_q, win_d, acc_q, acc_d;
  logic [LOG2_DECIM:0]                sum;
  logic                               win_end;
  logic [OUT_W-1:0]                   scaled, sample;

  logic [FIFO_DEPTH-1:0][OUT_W-1:0]   mem_q;
  logic [PTR_W-1:0]                   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               ovf_q, ovf_d;
  logic                               full, empty, pop, wr_en;

  assign win_end = &win_q;
  assign sum     = {1'b0, acc_q} + {{LOG2_DECIM{1'b0}}, pwmIn_i};
  assign win_d   = win_q + 1'b1;
  assign acc_d   = win_end ? '0 : sum[LOG2_DECIM-1:0];

  // A full window of highs cannot be represented by the shift, so it saturates.
  always_comb begin
    if (sum[LOG2_DECIM]) scaled = '1;
    else                 scaled = {sum[LOG2_DECIM-1:0], {PAD_W{1'b0}}};
    sample = scaled;
    if (SIGNED_OUT) sample[OUT_W-1] = ~scaled[OUT_W-1];
  end

  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = !empty && sampleReady_i;
  // When full, a same-edge pop frees the head slot, which is the write slot.
  assign wr_en = win_end && (!full || pop);

  assign wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
  assign rd_d  = pop   ? rd_q + 1'b1 : rd_q;
  assign cnt_d = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
  assign ovf_d = ovf_q || (win_end && full && !pop);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      win_q <= '0;
      acc_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      mem_q <= '0;
    end else begin
      win_q <= win_d;
      acc_q <= acc_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (wr_en) mem_q[wr_q] <= sample;
    end
  end

  assign sampleValid_o = !empty;
  assign sampleData_o  = empty ? '0 : mem_q[rd_q];
  assign fifoCount_o   = cnt_q;
  assign overflow_o    = ovf_q;

endmodule
